// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard detection and pipeline control for the 5-stage MIPS core.
//   Produces the stall/flush controls for the IF/ID and ID/EX pipeline
//   registers, the EX/ID forwarding selects, a multi-cycle mult/div sequencer
//   that holds decode for MD_LATENCY cycles, and a saturating stall counter.
//
// Ports
//   clk, reset            : pipeline clock, asynchronous active-high reset
//   rsd, rtd, rse, rte    : source register fields in decode / execute
//   writerege/m/w         : destination registers in execute/memory/writeback
//   regwritee/m/w         : stage writes a register
//   memtorege/m           : stage instruction is a load
//   branchd, pcsrcd       : decode branch, branch taken
//   mdstartd              : decode instruction is a multi-cycle mult/div
//   stall_clr             : synchronous clear of stall_count
//   stallf, stalld        : hold PC / IF/ID register
//   flushd, flushe        : clear IF/ID / ID/EX register
//   forwardad, forwardbd  : decode operand taken from memory-stage ALU result
//   forwardae, forwardbe  : EX select, 00 regfile, 01 writeback, 10 memory
//   mdbusy, mddone        : sequencer busy / one-cycle release pulse
//   stall_count           : saturating count of cycles with stalld=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsd,
  input  logic [4:0]       rtd,
  input  logic [4:0]       rse,
  input  logic [4:0]       rte,
  input  logic [4:0]       writerege,
  input  logic [4:0]       writeregm,
  input  logic [4:0]       writeregw,
  input  logic             regwritee,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             memtorege,
  input  logic             memtoregm,
  input  logic             branchd,
  input  logic             pcsrcd,
  input  logic             mdstartd,
  input  logic             stall_clr,
  output logic             stallf,
  output logic             stalld,
  output logic             flushd,
  output logic             flushe,
  output logic             forwardad,
  output logic             forwardbd,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             mdbusy,
  output logic             mddone,
  output logic [CNT_W-1:0] stall_count
);

  localparam int CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0]    MD_LOAD = CW'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } md_state_t;

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    md_cnt_reg, md_cnt_next;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;

  logic lwstall, branchstall, mdstall, stall_any;
  logic md_busy_raw, md_done_raw;

  // Per-operand forwarding: index 0 is the rs path, index 1 the rt path.
  logic [4:0] src_e [2];
  logic [4:0] src_d [2];
  logic [1:0] fwd_e [2];
  logic       fwd_d [2];

  assign src_e[0] = rse;
  assign src_e[1] = rte;
  assign src_d[0] = rsd;
  assign src_d[1] = rtd;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // Memory stage is younger than writeback, so it wins.
      always_comb begin
        fwd_e[gi] = 2'b00;
        if (src_e[gi] != 5'd0 && regwritem && src_e[gi] == writeregm)
          fwd_e[gi] = 2'b10;
        else if (src_e[gi] != 5'd0 && regwritew && src_e[gi] == writeregw)
          fwd_e[gi] = 2'b01;
      end
      assign fwd_d[gi] = (src_d[gi] != 5'd0) && regwritem && (src_d[gi] == writeregm);
    end
  endgenerate

  assign lwstall = memtorege && (rte == rsd || rte == rtd);

  // A branch resolves in decode, so it must wait for an ALU result still in
  // execute or for a load result still in memory.
  assign branchstall = branchd &&
      ((regwritee && (writerege == rsd || writerege == rtd)) ||
       (memtoregm && (writeregm == rsd || writeregm == rtd)));

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      md_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  // The IDLE cycle in which mdstartd is seen already counts as a stall cycle,
  // so BUSY lasts MD_LATENCY-1 cycles and the op leaves decode in DONE.
  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    mdstall     = 1'b0;
    md_busy_raw = 1'b0;
    md_done_raw = 1'b0;
    case (state_reg)
      IDLE: begin
        mdstall = mdstartd;
        // Start only once the operands are hazard-free.
        if (mdstartd && !lwstall && !branchstall) begin
          state_next  = BUSY;
          md_cnt_next = MD_LOAD;
        end
      end
      BUSY: begin
        mdstall     = 1'b1;
        md_busy_raw = 1'b1;
        if (md_cnt_reg == '0)
          state_next = DONE;
        else
          md_cnt_next = md_cnt_reg - CW'(1);
      end
      DONE: begin
        md_done_raw = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next  = IDLE;
        md_cnt_next = '0;
      end
    endcase
  end

  assign stall_any = lwstall | branchstall | mdstall;

  // Reset forces a safe pipeline: nothing held, both registers bubbled.
  assign stallf    = !reset && stall_any;
  assign stalld    = !reset && stall_any;
  assign flushe    = reset || stall_any;
  assign flushd    = reset || (pcsrcd && !stall_any);
  assign forwardae = reset ? 2'b00 : fwd_e[0];
  assign forwardbe = reset ? 2'b00 : fwd_e[1];
  assign forwardad = !reset && fwd_d[0];
  assign forwardbd = !reset && fwd_d[1];
  assign mdbusy    = !reset && md_busy_raw;
  assign mddone    = !reset && md_done_raw;

  always_comb begin
    stall_count_next = stall_count_reg;
    if (stall_clr)
      stall_count_next = '0;
    else if (stall_any && stall_count_reg != CNT_MAX)
      stall_count_next = stall_count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_reg <= '0;
    else
      stall_count_reg <= stall_count_next;
  end

  assign stall_count = stall_count_reg;

endmodule
